// File: rtl/params_loader.sv
// Parameter-memory loader: takes a (base, count, format) command, then streams
// handshaked CompFx_t words into one registered write per word at sequential addresses.
package params_loader_pkg;
  localparam int CIM_PARAMS_BANK_SIZE_NUM_WORD = 64;
  localparam int N_COMP = 16;

  typedef enum logic [2:0] {
    PARAMS_FX_1_X = 3'd0,
    PARAMS_FX_2_X = 3'd1,
    PARAMS_FX_3_X = 3'd2,
    PARAMS_FX_4_X = 3'd3,
    PARAMS_FX_5_X = 3'd4,
    PARAMS_FX_6_X = 3'd5,
    PARAMS_FX_7_X = 3'd6,
    PARAMS_FX_8_X = 3'd7
  } FxFormatParams_t;
endpackage

module params_loader #(
  parameter int PARAMS_DEPTH = 2 * params_loader_pkg::CIM_PARAMS_BANK_SIZE_NUM_WORD,
  parameter int ADDR_W       = $clog2(PARAMS_DEPTH),
  parameter int N_COMP       = params_loader_pkg::N_COMP
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              abort,
  input  logic [ADDR_W-1:0]                 base_addr,
  input  logic [ADDR_W:0]                   num_words,
  input  params_loader_pkg::FxFormatParams_t format,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [N_COMP-1:0]                 in_data,
  output logic                              wr_chip_en,
  output logic                              wr_en,
  output logic [ADDR_W-1:0]                 wr_addr,
  output logic [N_COMP-1:0]                 wr_data,
  output params_loader_pkg::FxFormatParams_t wr_format,
  output logic                              busy,
  output logic                              done,
  output logic                              err,
  output logic [N_COMP-1:0]                 checksum
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [ADDR_W+1:0] DEPTH_EXT = (ADDR_W+2)'(PARAMS_DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ZERO  = {(ADDR_W+1){1'b0}};

  state_t                             state_r;
  state_t                             state_next;
  logic [ADDR_W-1:0]                  base_r;
  logic [ADDR_W:0]                    num_r;
  logic [ADDR_W:0]                    count_r;
  params_loader_pkg::FxFormatParams_t format_r;
  logic [N_COMP-1:0]                  checksum_r;
  logic                               err_r;
  logic                               done_r;
  logic                               wr_en_r;
  logic [ADDR_W-1:0]                  wr_addr_r;
  logic [N_COMP-1:0]                  wr_data_r;

  logic [ADDR_W+1:0] end_s;
  logic              range_bad_s;
  logic              cmd_s;
  logic              last_s;
  logic              in_ready_s;
  logic              accept_s;

  // The end address is widened by two bits so base+count can never wrap.
  assign end_s       = {2'b00, base_addr} + {1'b0, num_words};
  assign range_bad_s = end_s > DEPTH_EXT;
  assign cmd_s       = (state_r == ST_IDLE) && start && !abort;
  assign last_s      = (count_r + CNT_ONE) == num_r;
  assign accept_s    = in_valid && in_ready_s;

  // Next-state decode and handshake readiness.
  always_comb begin
    state_next = state_r;
    in_ready_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cmd_s && !range_bad_s && (num_words != CNT_ZERO)) begin
          state_next = ST_LOAD;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_LOAD: begin
        in_ready_s = !abort;
        if (abort) begin
          state_next = ST_IDLE;
        end else if (in_valid && last_s) begin
          state_next = ST_FLUSH;
        end else begin
          state_next = ST_LOAD;
        end
      end
      ST_FLUSH: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  // Command latch, word counter, checksum and the one-entry write stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_r     <= {ADDR_W{1'b0}};
      num_r      <= CNT_ZERO;
      count_r    <= CNT_ZERO;
      format_r   <= params_loader_pkg::PARAMS_FX_4_X;
      checksum_r <= {N_COMP{1'b0}};
      err_r      <= 1'b0;
      done_r     <= 1'b0;
      wr_en_r    <= 1'b0;
      wr_addr_r  <= {ADDR_W{1'b0}};
      wr_data_r  <= {N_COMP{1'b0}};
    end else begin
      done_r  <= 1'b0;
      wr_en_r <= 1'b0;
      if (cmd_s) begin
        base_r     <= base_addr;
        num_r      <= num_words;
        format_r   <= format;
        count_r    <= CNT_ZERO;
        checksum_r <= {N_COMP{1'b0}};
        err_r      <= range_bad_s;
        done_r     <= !range_bad_s && (num_words == CNT_ZERO);
      end else if (accept_s) begin
        wr_en_r    <= 1'b1;
        wr_addr_r  <= base_r + count_r[ADDR_W-1:0];
        wr_data_r  <= in_data;
        checksum_r <= checksum_r + in_data;
        count_r    <= count_r + CNT_ONE;
      end else if ((state_r == ST_FLUSH) && !abort) begin
        done_r <= 1'b1;
      end
    end
  end

  assign in_ready   = in_ready_s;
  assign busy       = (state_r != ST_IDLE);
  assign wr_chip_en = (state_r != ST_IDLE);
  assign wr_en      = wr_en_r;
  assign wr_addr    = wr_addr_r;
  assign wr_data    = wr_data_r;
  assign wr_format  = format_r;
  assign done       = done_r;
  assign err        = err_r;
  assign checksum   = checksum_r;

endmodule

// File: tb/tb_params_loader.sv
// Bench for params_loader: table of load commands plus hand sequences for
// command collision and mid-load reset; writes are checked through a scoreboard.
module tb_params_loader;
  import params_loader_pkg::*;

  localparam int BANK  = CIM_PARAMS_BANK_SIZE_NUM_WORD;
  localparam int DEPTH = 2 * BANK;
  localparam int AW    = $clog2(DEPTH);
  localparam int NC    = N_COMP;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic            abort;
  logic [AW-1:0]   base_addr;
  logic [AW:0]     num_words;
  FxFormatParams_t format;
  logic            in_valid;
  logic            in_ready;
  logic [NC-1:0]   in_data;
  logic            wr_chip_en;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [NC-1:0]   wr_data;
  FxFormatParams_t wr_format;
  logic            busy;
  logic            done;
  logic            err;
  logic [NC-1:0]   checksum;

  params_loader #(.PARAMS_DEPTH(DEPTH), .ADDR_W(AW), .N_COMP(NC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .base_addr(base_addr), .num_words(num_words), .format(format),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .wr_chip_en(wr_chip_en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_format(wr_format), .busy(busy), .done(done), .err(err), .checksum(checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int              base;
    int              num;
    FxFormatParams_t fmt;
    int              seed;
    bit              gap;
    int              abort_after;
    bit              collide;
    bit              exp_err;
    int              exp_writes;
    int              exp_done;
    int              exp_done_cyc;
  } vec_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [NC-1:0] data;
  } wr_t;

  wr_t             exp_q[$];
  wr_t             mon_e;
  FxFormatParams_t exp_fmt;
  int              n_vec;
  int              n_err;
  vec_t            vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every write must match the oldest expected write.
  always @(negedge clk) begin
    if (wr_en) begin
      chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
        chk("wr_data", 32'(wr_data), 32'(mon_e.data));
        chk("wr_format", 32'(wr_format), 32'(exp_fmt));
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, "_wr_chip_en"}, 32'(wr_chip_en), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    chk({tag, "_wr_data"}, 32'(wr_data), 32'd0);
    chk({tag, "_checksum"}, 32'(checksum), 32'd0);
    chk({tag, "_wr_format"}, 32'(wr_format), 32'(PARAMS_FX_4_X));
  endtask

  task automatic run_vec(input vec_t v);
    int acc, cyc, done_n, done_cyc, stop_cyc, abort_cyc;
    bit busy_seen, aborted;
    acc = 0; done_n = 0; done_cyc = -1; stop_cyc = -1; abort_cyc = -1;
    busy_seen = 1'b0; aborted = 1'b0;
    exp_fmt   = v.fmt;
    base_addr = AW'(v.base);
    num_words = (AW+1)'(v.num);
    format    = v.fmt;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc <= 300) begin
      if (done) begin
        done_n++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (busy) busy_seen = 1'b1;
      if (aborted && cyc == abort_cyc + 1) begin
        chk("abort_in_ready", 32'(in_ready), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
      end
      if (stop_cyc < 0 && done_cyc > 0) stop_cyc = cyc + 2;
      if (stop_cyc < 0 && v.exp_err) stop_cyc = cyc + 3;
      if (cyc == stop_cyc) break;
      abort    = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      if (v.collide && cyc == 2) begin
        start     = 1'b1;
        base_addr = '0;
        num_words = (AW+1)'(1);
      end
      if (!aborted && v.abort_after > 0 && acc == v.abort_after) begin
        abort     = 1'b1;
        aborted   = 1'b1;
        abort_cyc = cyc;
        stop_cyc  = cyc + 4;
      end else if (!aborted && acc < v.num && (!v.gap || (cyc % 2 == 1))) begin
        in_valid = 1'b1;
        in_data  = NC'((acc + 1) * v.seed);
      end
      #1;
      if (in_valid && in_ready) begin
        exp_q.push_back({AW'(v.base + acc), in_data});
        acc++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    abort    = 1'b0;
    start    = 1'b0;
    chk("finished_in_budget", 32'(cyc <= 300), 32'd1);
    chk("err", 32'(err), 32'(v.exp_err));
    chk("accepts", 32'(acc), 32'(v.exp_writes));
    chk("done_count", 32'(done_n), 32'(v.exp_done));
    chk("done_cycle", 32'(done_cyc), 32'(v.exp_done_cyc));
    chk("busy_seen", 32'(busy_seen), 32'(v.exp_writes > 0));
    chk("checksum", 32'(checksum), 32'(NC'(v.seed * v.exp_writes * (v.exp_writes + 1) / 2)));
    chk("writes_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    base_addr = '0; num_words = '0; format = PARAMS_FX_1_X; in_data = '0;
    exp_fmt = PARAMS_FX_4_X;

    //          base       num fmt            seed     gap  abt col  err wr done cyc
    vecs[0] = '{0,         4, PARAMS_FX_3_X, 'h0100, 1'b0, 0, 1'b0, 1'b0, 4, 1,  6};
    vecs[1] = '{BANK - 2,  4, PARAMS_FX_2_X, 'h0011, 1'b1, 0, 1'b0, 1'b0, 4, 1,  9};
    vecs[2] = '{DEPTH - 2, 3, PARAMS_FX_5_X, 'h0001, 1'b0, 0, 1'b0, 1'b1, 0, 0, -1};
    vecs[3] = '{5,         0, PARAMS_FX_1_X, 'h0001, 1'b0, 0, 1'b0, 1'b0, 0, 1,  1};
    vecs[4] = '{10,        8, PARAMS_FX_6_X, 'h0101, 1'b0, 3, 1'b0, 1'b0, 3, 0, -1};
    vecs[5] = '{20,        2, PARAMS_FX_4_X, 'h1234, 1'b0, 0, 1'b0, 1'b0, 2, 1,  4};
    vecs[6] = '{DEPTH - 4, 4, PARAMS_FX_8_X, 'h7000, 1'b0, 0, 1'b0, 1'b0, 4, 1,  6};
    vecs[7] = '{30,        3, PARAMS_FX_7_X, 'h0003, 1'b0, 0, 1'b1, 1'b0, 3, 1,  5};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("reset");

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // start and abort together in IDLE: nothing may happen.
    base_addr = '0; num_words = (AW+1)'(2); format = PARAMS_FX_2_X;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0; in_valid = 1'b1; in_data = NC'(16'hDEAD);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("collide_busy", 32'(busy), 32'd0);
      chk("collide_in_ready", 32'(in_ready), 32'd0);
      chk("collide_done", 32'(done), 32'd0);
    end
    in_valid = 1'b0;

    // Reset in the middle of a load.
    exp_fmt = PARAMS_FX_2_X;
    base_addr = AW'(40); num_words = (AW+1)'(6); format = PARAMS_FX_2_X;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      in_data  = NC'(16'h0A00 + k);
      #1;
      if (in_valid && in_ready) exp_q.push_back({AW'(40 + k), in_data});
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("midload_busy", 32'(busy), 32'd1);
    chk("midload_chip_en", 32'(wr_chip_en), 32'd1);
    chk("midload_checksum", 32'(checksum), 32'h1401);
    in_valid = 1'b1;
    in_data  = NC'(16'h5555);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("async_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_reset_busy", 32'(busy), 32'd0);
      chk("post_reset_wr_en", 32'(wr_en), 32'd0);
    end
    in_valid = 1'b0;
    chk("post_reset_queue", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
